score_sequencer: RTL and testbench

SCORE_SEQUENCER -- requirements
Module: score_sequencer

---
 rtl/beeper_pkg.sv | 44 ++++
 rtl/score_rom.sv | 21 ++
 rtl/score_sequencer.sv | 142 ++++++++++++++
 tb/tb_score_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/beeper_pkg.sv
// Shared definitions for the score sequencer and beeper: FSM encoding, score entry
// layout, special tone codes and lifting-mark encodings.
package beeper_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_NOTE, S_GAP} state_e;

  localparam int TONE_W   = 5;
  localparam int MARK_W   = 2;
  localparam int DUR_W    = 3;
  localparam int ENTRY_W  = MARK_W + TONE_W + DUR_W;
  localparam int DUR_LSB  = 0;
  localparam int TONE_LSB = DUR_LSB + DUR_W;
  localparam int MARK_LSB = TONE_LSB + TONE_W;

  localparam logic [TONE_W-1:0] REST_TONE = 5'd0;
  localparam logic [TONE_W-1:0] END_TONE  = 5'd31;
  localparam logic [TONE_W-1:0] MAX_TONE  = 5'd21;

  localparam logic [MARK_W-1:0] MARK_NAT   = 2'b00;
  localparam logic [MARK_W-1:0] MARK_FLAT  = 2'b01;
  localparam logic [MARK_W-1:0] MARK_SHARP = 2'b10;

  typedef struct packed {
    logic [MARK_W-1:0] mark;
    logic [TONE_W-1:0] tone;
    logic [DUR_W-1:0]  dur;
  } entry_t;

  typedef struct packed {
    logic [TONE_W-1:0] tone;
    logic [MARK_W-1:0] mark;
    logic              en;
  } beep_t;

  // Codes 22..30 are unassigned and play as silence, same as an explicit rest.
  function automatic logic audible(input logic [TONE_W-1:0] t);
    return (t != REST_TONE) && (t <= MAX_TONE);
  endfunction

  function automatic logic [ENTRY_W-1:0] mk_entry(input logic [MARK_W-1:0] m,
                                                  input logic [TONE_W-1:0] t,
                                                  input logic [DUR_W-1:0]  d);
    return {m, t, d};
  endfunction
endpackage

// File: rtl/score_rom.sv
// Score storage: SCORE_LEN x ENTRY_W constant table with a registered read port
// (one cycle from addr to data).
module score_rom
  import beeper_pkg::*;
#(
  parameter int SCORE_LEN = 64,
  parameter int ADDR_W    = 6,
  parameter logic [SCORE_LEN*ENTRY_W-1:0] INIT = '0
) (
  input  logic              clk_in,
  input  logic [ADDR_W-1:0] addr,
  output entry_t            data
);
  logic [ENTRY_W-1:0] mem [SCORE_LEN];

  for (genvar i = 0; i < SCORE_LEN; i++) begin : g_mem
    assign mem[i] = INIT[i*ENTRY_W +: ENTRY_W];
  end

  always_ff @(posedge clk_in) data <= entry_t'(mem[addr]);
endmodule

// File: rtl/score_sequencer.sv
// Walks the score ROM and drives tone/lifting_mark/tone_en to the beeper, with
// per-note duration, articulation gap, looping, stop and a manual key override.
module score_sequencer
  import beeper_pkg::*;
#(
  parameter int UNIT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_000_000,
  parameter int SCORE_LEN   = 64,
  localparam int ADDR_W     = (SCORE_LEN > 1) ? $clog2(SCORE_LEN) : 1,
  parameter logic [SCORE_LEN*ENTRY_W-1:0] SCORE_DATA =
    {{((SCORE_LEN-4)*ENTRY_W){1'b0}},
     mk_entry(MARK_NAT, END_TONE, 3'd0), mk_entry(MARK_NAT, 5'd5, 3'd3),
     mk_entry(MARK_NAT, 5'd3, 3'd1),     mk_entry(MARK_NAT, 5'd1, 3'd1)}
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              play,
  input  logic              stop,
  input  logic              loop,
  input  logic              key_valid,
  input  logic [TONE_W-1:0] key_tone,
  input  logic [MARK_W-1:0] key_mark,
  output logic [TONE_W-1:0] tone,
  output logic [MARK_W-1:0] lifting_mark,
  output logic              tone_en,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] note_idx
);
  localparam int NOTE_MAX = 8 * UNIT_CYCLES;
  localparam int CNT_MAX  = (NOTE_MAX > GAP_CYCLES) ? NOTE_MAX : GAP_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SCORE_LEN - 1);

  state_e             state_q, state_d;
  logic               ph_q, ph_d;
  logic [ADDR_W-1:0]  idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  beep_t              seq_q, seq_d;
  logic               done_d, eos;
  entry_t             rom_q;
  logic [CNT_W-1:0]   note_len;

  score_rom #(.SCORE_LEN(SCORE_LEN), .ADDR_W(ADDR_W), .INIT(SCORE_DATA)) u_rom (
    .clk_in (clk_in),
    .addr   (note_idx),
    .data   (rom_q)
  );

  assign note_len = CNT_W'({1'b0, rom_q.dur} + 4'd1) * CNT_W'(UNIT_CYCLES);

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    idx_d   = note_idx;
    cnt_d   = cnt_q;
    seq_d   = seq_q;
    done_d  = 1'b0;
    eos     = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
      ph_d    = 1'b0;
      idx_d   = '0;
      cnt_d   = '0;
      seq_d   = '0;
    end else if (!key_valid) begin
      // A held manual key freezes everything below, so no branch runs.
      case (state_q)
        S_IDLE: if (play) begin
          state_d = S_FETCH;
          ph_d    = 1'b0;
          idx_d   = '0;
        end
        S_FETCH: begin
          ph_d = ~ph_q;
          if (ph_q) begin
            if (rom_q.tone == END_TONE) eos = 1'b1;
            else begin
              state_d = S_NOTE;
              cnt_d   = note_len - CNT_W'(1);
              seq_d   = '{tone: rom_q.tone, mark: rom_q.mark, en: audible(rom_q.tone)};
            end
          end
        end
        S_NOTE: begin
          if (cnt_q == '0) begin
            state_d  = S_GAP;
            cnt_d    = CNT_W'(GAP_CYCLES - 1);
            seq_d.en = 1'b0;
          end else cnt_d = cnt_q - CNT_W'(1);
        end
        S_GAP: begin
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
          else if (note_idx == LAST_IDX) eos = 1'b1;
          else begin
            state_d = S_FETCH;
            ph_d    = 1'b0;
            idx_d   = note_idx + ADDR_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
      // End of score, either by marker or by running off the last entry.
      if (eos) begin
        idx_d = '0;
        ph_d  = 1'b0;
        if (loop) state_d = S_FETCH;
        else begin
          state_d = S_IDLE;
          seq_d   = '0;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= S_IDLE;
      ph_q         <= 1'b0;
      note_idx     <= '0;
      cnt_q        <= '0;
      seq_q        <= '0;
      tone         <= '0;
      lifting_mark <= '0;
      tone_en      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      note_idx     <= idx_d;
      cnt_q        <= cnt_d;
      seq_q        <= seq_d;
      tone         <= key_valid ? key_tone : seq_d.tone;
      lifting_mark <= key_valid ? key_mark : seq_d.mark;
      tone_en      <= key_valid | seq_d.en;
      busy         <= (state_d != S_IDLE);
      done         <= done_d;
    end
  end
endmodule

// File: tb/tb_score_sequencer.sv
// Bench for score_sequencer: segment scoreboard over table-driven playback runs,
// plus directed loop, stop, play/stop collision and reset sequences.
module tb_score_sequencer;
  import beeper_pkg::*;

  function automatic logic [9:0] mk(input logic [1:0] m, input logic [4:0] t, input logic [2:0] d);
    return {m, t, d};
  endfunction

  localparam logic [79:0] ROM_A = {mk(0,0,0), mk(0,0,0), mk(0,0,0), mk(0,0,0), mk(0,0,0),
                                   mk(0,31,0), mk(2,3,0), mk(0,8,1)};
  localparam logic [79:0] ROM_B = {mk(1,12,1), mk(0,7,0), mk(0,6,0), mk(0,5,0),
                                   mk(2,21,0), mk(0,25,0), mk(1,1,0), mk(0,0,2)};

  logic clk = 0, rst_n = 0;
  logic play_a = 0, play_b = 0, stop = 0, loop = 0, key_valid = 0;
  logic [4:0] key_tone = 0;
  logic [1:0] key_mark = 0;
  logic [4:0] tone_a, tone_b;
  logic [1:0] mark_a, mark_b;
  logic en_a, en_b, busy_a, busy_b, done_a, done_b;
  logic [2:0] idx_a, idx_b;

  always #5 clk = ~clk;

  score_sequencer #(.UNIT_CYCLES(10), .GAP_CYCLES(2), .SCORE_LEN(8), .SCORE_DATA(ROM_A)) u_a (
    .clk_in(clk), .rst_n_in(rst_n), .play(play_a), .stop(stop), .loop(loop),
    .key_valid(key_valid), .key_tone(key_tone), .key_mark(key_mark),
    .tone(tone_a), .lifting_mark(mark_a), .tone_en(en_a), .busy(busy_a), .done(done_a),
    .note_idx(idx_a));

  score_sequencer #(.UNIT_CYCLES(10), .GAP_CYCLES(2), .SCORE_LEN(8), .SCORE_DATA(ROM_B)) u_b (
    .clk_in(clk), .rst_n_in(rst_n), .play(play_b), .stop(stop), .loop(loop),
    .key_valid(key_valid), .key_tone(key_tone), .key_mark(key_mark),
    .tone(tone_b), .lifting_mark(mark_b), .tone_en(en_b), .busy(busy_b), .done(done_b),
    .note_idx(idx_b));

  typedef struct {int id; logic [4:0] tone; logic [1:0] mark; logic en; int len;} seg_t;
  typedef struct {int sel; logic lp; logic key;} vec_t;

  int n_tests = 0, n_fail = 0;
  int sel = 0;
  logic sb_en = 0;
  logic [23:0] sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [4:0] m_tone; logic [1:0] m_mark; logic m_en, m_busy, m_done;
  assign m_tone = sel ? tone_b : tone_a;
  assign m_mark = sel ? mark_b : mark_a;
  assign m_en   = sel ? en_b   : en_a;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_done = sel ? done_b : done_a;

  // Collapse DUT output into runs of constant {tone,mark,en} while busy.
  logic run_on = 0, dchk = 0;
  logic [7:0] run_key;
  int run_len;

  task automatic close_run();
    if (sbq.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL seg_extra: got %0h with no expected segment", {run_key, 16'(run_len)});
    end else chk("seg", {8'h0, run_key, 16'(run_len)}, {8'h0, sbq.pop_front()});
  endtask

  always @(negedge clk) begin
    if (!sb_en) begin
      run_on = 0; dchk = 0;
    end else begin
      if (dchk) begin chk("done_width", m_done, 0); dchk = 0; end
      if (m_busy) begin
        if (run_on && {m_tone, m_mark, m_en} == run_key) run_len++;
        else begin
          if (run_on) close_run();
          run_on = 1; run_key = {m_tone, m_mark, m_en}; run_len = 1;
        end
      end else if (run_on) begin
        close_run();
        run_on = 0;
        chk("done_at_end", m_done, 1);
        dchk = 1;
      end
    end
  end

  task automatic pulse_play(input int s);
    @(posedge clk); #1;
    if (s == 0) play_a = 1; else play_b = 1;
    @(posedge clk); #1;
    play_a = 0; play_b = 0;
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1 stop = 1;
    @(posedge clk); #1 stop = 0;
  endtask

  seg_t segs[$];
  vec_t vecs[$];

  initial begin
    int n;
    logic wrapped, saw_done, leak;
    logic [2:0] prev_idx;

    segs.push_back(seg_t'{0, 0, 0, 0, 2});  segs.push_back(seg_t'{0, 8, 0, 1, 20});
    segs.push_back(seg_t'{0, 8, 0, 0, 4});  segs.push_back(seg_t'{0, 3, 2, 1, 10});
    segs.push_back(seg_t'{0, 3, 2, 0, 4});
    segs.push_back(seg_t'{1, 0, 0, 0, 36}); segs.push_back(seg_t'{1, 1, 1, 1, 10});
    segs.push_back(seg_t'{1, 1, 1, 0, 4});  segs.push_back(seg_t'{1, 25, 0, 0, 14});
    segs.push_back(seg_t'{1, 21, 2, 1, 10}); segs.push_back(seg_t'{1, 21, 2, 0, 4});
    segs.push_back(seg_t'{1, 5, 0, 1, 10}); segs.push_back(seg_t'{1, 5, 0, 0, 4});
    segs.push_back(seg_t'{1, 6, 0, 1, 10}); segs.push_back(seg_t'{1, 6, 0, 0, 4});
    segs.push_back(seg_t'{1, 7, 0, 1, 10}); segs.push_back(seg_t'{1, 7, 0, 0, 4});
    segs.push_back(seg_t'{1, 12, 1, 1, 20}); segs.push_back(seg_t'{1, 12, 1, 0, 2});
    segs.push_back(seg_t'{2, 0, 0, 0, 2});  segs.push_back(seg_t'{2, 8, 0, 1, 6});
    segs.push_back(seg_t'{2, 12, 1, 1, 5}); segs.push_back(seg_t'{2, 8, 0, 1, 14});
    segs.push_back(seg_t'{2, 8, 0, 0, 4});  segs.push_back(seg_t'{2, 3, 2, 1, 10});
    segs.push_back(seg_t'{2, 3, 2, 0, 4});
    vecs.push_back(vec_t'{0, 0, 0});
    vecs.push_back(vec_t'{1, 0, 0});
    vecs.push_back(vec_t'{0, 0, 1});

    #23;
    chk("rst_tone", tone_a, 0);   chk("rst_mark", mark_a, 0);
    chk("rst_en", en_a, 0);       chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);   chk("rst_idx", idx_a, 0);
    chk("rst_b_en", en_b, 0);
    @(posedge clk); #1 rst_n = 1;
    repeat (2) @(posedge clk);

    for (int t = 0; t < vecs.size(); t++) begin
      sel = vecs[t].sel; loop = vecs[t].lp;
      for (int i = 0; i < segs.size(); i++)
        if (segs[i].id == t) sbq.push_back({segs[i].tone, segs[i].mark, segs[i].en, 16'(segs[i].len)});
      sb_en = 1;
      pulse_play(sel);
      if (vecs[t].key) begin
        key_tone = 5'd12; key_mark = 2'b01;
        repeat (7) @(posedge clk); #1 key_valid = 1;
        repeat (5) @(posedge clk); #1 key_valid = 0;
      end else begin
        repeat (10) @(posedge clk);
        pulse_play(sel);
      end
      n = 0;
      while ((sbq.size() != 0 || run_on) && n < 3000) begin @(negedge clk); n++; end
      chk("run_complete", n < 3000, 1);
      repeat (2) @(negedge clk);
      sb_en = 0;
      sbq.delete();
      pulse_stop();
    end

    // Loop: end marker wraps note_idx 2 -> 0 with no done pulse; then stop mid-note.
    sel = 0; loop = 1;
    pulse_play(0);
    wrapped = 0; saw_done = 0; prev_idx = 0; n = 0;
    while (!wrapped && n < 500) begin
      @(negedge clk); n++;
      if (prev_idx == 3'd2 && idx_a == 3'd0) wrapped = 1;
      if (done_a) saw_done = 1;
      prev_idx = idx_a;
    end
    chk("loop_wrap", wrapped, 1);
    n = 0;
    while (!(idx_a == 3'd1 && en_a) && n < 500) begin
      @(negedge clk); n++;
      if (done_a) saw_done = 1;
    end
    chk("loop_no_done", saw_done, 0);
    chk("loop_idx1", idx_a, 1);
    pulse_stop();
    @(negedge clk);
    chk("stop_en", en_a, 0);   chk("stop_idx", idx_a, 0);
    chk("stop_busy", busy_a, 0); chk("stop_done", done_a, 0);
    loop = 0;

    // play and stop together in IDLE: stop wins.
    @(posedge clk); #1 play_a = 1; stop = 1;
    @(posedge clk); #1 play_a = 0; stop = 0;
    @(negedge clk);
    chk("playstop_busy", busy_a, 0);
    repeat (5) @(negedge clk);
    chk("playstop_busy_later", busy_a, 0);
    chk("playstop_en", en_a, 0);

    // Asynchronous reset mid-note, then silence until a new play.
    pulse_play(0);
    n = 0;
    while (!en_a && n < 100) begin @(negedge clk); n++; end
    chk("pre_rst_en", en_a, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_rst_en", en_a, 0);
    chk("async_rst_busy", busy_a, 0);
    chk("async_rst_idx", idx_a, 0);
    @(posedge clk); #1 rst_n = 1;
    leak = 0;
    repeat (60) begin @(negedge clk); if (en_a || busy_a) leak = 1; end
    chk("post_rst_silent", leak, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
